// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory depth
// and requester port ids.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam int   DMEM_DEPTH = 256;
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DMA   = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the data-memory control bus.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant. On contention the port not granted last wins;
// the pointer moves only when the grant is actually taken.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_last;
  logic w_id;

  always_comb begin
    w_id = i_req[1];
    if (i_req == 2'b11) begin
      w_id = ~r_last;
    end
  end

  assign o_gnt_valid = |i_req;
  assign o_gnt_id    = w_id;

  // Reset as "DMA granted last" so the CPU port wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_DMA;
    end else if (i_accept) begin
      r_last <= w_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and DMA ports. Each access
// is latched, driven for exactly one cycle, then answered with a tagged response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_accept;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_oor;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       ({bus.req1_valid, bus.req0_valid}),
    .i_accept    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // rst_n gates the ready path so no handshake completes while reset is held.
  assign w_accept    = rst_n && (r_state == ST_IDLE) && w_gnt_valid;
  assign w_sel_we    = (w_gnt_id == PORT_DMA) ? bus.req1_we    : bus.req0_we;
  assign w_sel_addr  = (w_gnt_id == PORT_DMA) ? bus.req1_addr  : bus.req0_addr;
  assign w_sel_wdata = (w_gnt_id == PORT_DMA) ? bus.req1_wdata : bus.req0_wdata;
  assign w_sel_oor   = (w_sel_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_port      <= PORT_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_port      <= w_gnt_id;
            r_we        <= w_sel_we;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_err       <= w_sel_oor;
            r_mem_read  <= !w_sel_oor && !w_sel_we;
            r_mem_write <= !w_sel_oor && w_sel_we;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_rsp_valid <= (r_port == PORT_DMA) ? 2'b10 : 2'b01;
          r_rsp_rdata <= (r_we || r_err) ? '0 : bus.mem_rdata;
          r_rsp_err   <= r_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 2'b00;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_accept && (w_gnt_id == PORT_CPU);
  assign bus.req1_ready = w_accept && (w_gnt_id == PORT_DMA);

  // Address and data stay parked on the bus from acceptance through RESP.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;

  assign bus.rsp0_valid = r_rsp_valid[0];
  assign bus.rsp0_rdata = r_rsp_valid[0] ? r_rsp_rdata : '0;
  assign bus.rsp0_err   = r_rsp_valid[0] && r_rsp_err;
  assign bus.rsp1_valid = r_rsp_valid[1];
  assign bus.rsp1_rdata = r_rsp_valid[1] ? r_rsp_rdata : '0;
  assign bus.rsp1_err   = r_rsp_valid[1] && r_rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        preload = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        last_grant;
  logic [7:0]  st;

  function automatic logic [31:0] init_word(input int i);
    return (i < 8) ? 32'(i) : ~32'(i);
  endfunction

  // Memory: combinational read, write on the clock edge while MemWrite is high.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  assign st = {bus.req0_ready, bus.req1_ready, bus.mem_read, bus.mem_write,
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err};

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic clr_reqs();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic apply_reset();
    clr_reqs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1'b1;
  endtask

  // Runs one single-port transaction and records what was seen in each cycle.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [7:0] s0, output logic [7:0] s1,
                     output logic [7:0] s2, output logic [7:0] s3,
                     output logic [31:0] ma, output logic [31:0] mw,
                     output logic [31:0] r0, output logic [31:0] r1);
    @(negedge clk); set_req(p, 1'b1, we, a, d); #1 s0 = st;
    @(negedge clk); clr_reqs(); #1 s1 = st; ma = bus.mem_addr; mw = bus.mem_wdata;
    @(negedge clk); #1 s2 = st; r0 = bus.rsp0_rdata; r1 = bus.rsp1_rdata;
    @(negedge clk); #1 s3 = st;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd256 + 32'($urandom_range(0, 100));
    if (r == 1) return $urandom;
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic test_reset();
    clr_reqs();
    set_req(0, 1'b1, 1'b1, 32'd9, 32'h55);
    set_req(1, 1'b1, 1'b0, 32'd3, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (st !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %b want %b", st, 8'h00); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin n_bad++; $display("FAIL reset_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if ({bus.rsp0_rdata, bus.rsp1_rdata} !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rsp0_rdata, bus.rsp1_rdata); end
    @(negedge clk);
    preload = 1'b0;
    clr_reqs();
    rst_n = 1'b1;
    $display("reset: status %b", st);
  endtask

  task automatic test_simultaneous();
    logic w;
    logic [31:0] a;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      w = k[0];
      a = w ? 32'd12 : 32'd3;
      @(negedge clk);
      if (k == 0) begin
        set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'd12, 32'd0);
      end
      #1;
      n_cmp++; if (st[7:6] !== (w ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL simul_grant%0d: got %b want %b", k, st[7:6], w ? 2'b01 : 2'b10); end
      @(negedge clk); #1;
      n_cmp++; if ({st, bus.mem_addr} !== {8'b0010_0000, a}) begin n_bad++; $display("FAIL simul_access%0d: got %b/%0d want %b/%0d", k, st, bus.mem_addr, 8'b0010_0000, a); end
      @(negedge clk); #1;
      n_cmp++; if (st !== (w ? 8'b0000_0100 : 8'b0000_1000)) begin n_bad++; $display("FAIL simul_rsp%0d: got %b", k, st); end
      n_cmp++; if ({bus.rsp0_rdata, bus.rsp1_rdata} !== (w ? {32'd0, ref_mem[12]} : {ref_mem[3], 32'd0})) begin n_bad++; $display("FAIL simul_rdata%0d: got %h/%h", k, bus.rsp0_rdata, bus.rsp1_rdata); end
      $display("simultaneous: grant %0d addr %0d", w, a);
    end
    @(negedge clk); clr_reqs();
  endtask

  task automatic test_load_p0();
    logic [7:0] s0, s1, s2, s3;
    logic [31:0] ma, mw, r0, r1;
    txn(0, 1'b0, 32'd7, 32'd0, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if (s0 !== 8'b1000_0000) begin n_bad++; $display("FAIL load_p0_ready: got %b want %b", s0, 8'b1000_0000); end
    n_cmp++; if ({s1, ma} !== {8'b0010_0000, 32'd7}) begin n_bad++; $display("FAIL load_p0_access: got %b/%0d want 00100000/7", s1, ma); end
    n_cmp++; if (s2 !== 8'b0000_1000) begin n_bad++; $display("FAIL load_p0_rsp: got %b want %b", s2, 8'b0000_1000); end
    n_cmp++; if ({r0, r1} !== {32'd7, 32'd0}) begin n_bad++; $display("FAIL load_p0_rdata: got %h/%h want 7/0", r0, r1); end
    n_cmp++; if (s3 !== 8'h00) begin n_bad++; $display("FAIL load_p0_idle: got %b want 0", s3); end
    $display("load_p0: rdata %h", r0);
  endtask

  task automatic test_store_load_p1();
    logic [7:0] s0, s1, s2, s3;
    logic [31:0] ma, mw, r0, r1;
    txn(1, 1'b1, 32'd15, 32'd15, s0, s1, s2, s3, ma, mw, r0, r1);
    ref_mem[15] = 32'd15;
    n_cmp++; if (s0 !== 8'b0100_0000) begin n_bad++; $display("FAIL store_p1_ready: got %b", s0); end
    n_cmp++; if ({s1, ma, mw} !== {8'b0001_0000, 32'd15, 32'd15}) begin n_bad++; $display("FAIL store_p1_access: got %b/%0d/%0d want 00010000/15/15", s1, ma, mw); end
    n_cmp++; if ({s2, r1, s3} !== {8'b0000_0100, 32'd0, 8'h00}) begin n_bad++; $display("FAIL store_p1_rsp: got %b/%h/%b", s2, r1, s3); end
    txn(1, 1'b0, 32'd15, 32'd0, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if (s1 !== 8'b0010_0000) begin n_bad++; $display("FAIL load_p1_access: got %b", s1); end
    n_cmp++; if ({s2, r0, r1} !== {8'b0000_0100, 32'd0, ref_mem[15]}) begin n_bad++; $display("FAIL load_p1_rdata: got %b/%h/%h want 00000100/0/%h", s2, r0, r1, ref_mem[15]); end
    $display("store_load_p1: rdata %h", r1);
  endtask

  task automatic test_out_of_range();
    logic [7:0] s0, s1, s2, s3;
    logic [31:0] ma, mw, r0, r1;
    txn(0, 1'b0, 32'd256, 32'd0, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if ({s1, s2, r0} !== {8'h00, 8'b0000_1010, 32'd0}) begin n_bad++; $display("FAIL oor_load256: got %b/%b/%h", s1, s2, r0); end
    txn(0, 1'b1, 32'd300, 32'hCAFE_F00D, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if ({s1, s2} !== {8'h00, 8'b0000_1010}) begin n_bad++; $display("FAIL oor_store300: got %b/%b", s1, s2); end
    n_cmp++; if (mem[44] !== ref_mem[44]) begin n_bad++; $display("FAIL oor_store_mem: got %h want %h", mem[44], ref_mem[44]); end
    txn(0, 1'b0, 32'd255, 32'd0, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if ({s1, s2, r0} !== {8'b0010_0000, 8'b0000_1000, ref_mem[255]}) begin n_bad++; $display("FAIL addr255: got %b/%b/%h want %h", s1, s2, r0, ref_mem[255]); end
    txn(1, 1'b0, 32'h8000_0007, 32'd0, s0, s1, s2, s3, ma, mw, r0, r1);
    n_cmp++; if ({s1, s2, r1} !== {8'h00, 8'b0000_0101, 32'd0}) begin n_bad++; $display("FAIL oor_nowrap: got %b/%b/%h", s1, s2, r1); end
    $display("out_of_range: last status %b", s2);
  endtask

  task automatic test_busy_ignore();
    @(negedge clk); set_req(0, 1'b1, 1'b0, 32'd5, 32'd0); #1;
    n_cmp++; if (st !== 8'b1000_0000) begin n_bad++; $display("FAIL busy_accept0: got %b", st); end
    @(negedge clk); set_req(0, 1'b0, 1'b0, 32'd0, 32'd0); set_req(1, 1'b1, 1'b0, 32'd9, 32'd0); #1;
    n_cmp++; if (st !== 8'b0010_0000) begin n_bad++; $display("FAIL busy_access: got %b want 00100000", st); end
    @(negedge clk); #1;
    n_cmp++; if ({st, bus.rsp0_rdata} !== {8'b0000_1000, ref_mem[5]}) begin n_bad++; $display("FAIL busy_resp: got %b/%h", st, bus.rsp0_rdata); end
    @(negedge clk); #1;
    n_cmp++; if (st !== 8'b0100_0000) begin n_bad++; $display("FAIL busy_accept1: got %b want 01000000", st); end
    @(negedge clk); clr_reqs(); #1;
    n_cmp++; if ({st, bus.mem_addr} !== {8'b0010_0000, 32'd9}) begin n_bad++; $display("FAIL busy_access1: got %b/%0d", st, bus.mem_addr); end
    @(negedge clk); #1;
    n_cmp++; if ({st, bus.rsp1_rdata} !== {8'b0000_0100, ref_mem[9]}) begin n_bad++; $display("FAIL busy_resp1: got %b/%h", st, bus.rsp1_rdata); end
    @(negedge clk);
    $display("busy_ignore: done");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); set_req(0, 1'b1, 1'b1, 32'd20, 32'h1234_5678); #1;
    n_cmp++; if (st !== 8'b1000_0000) begin n_bad++; $display("FAIL rmid_accept: got %b", st); end
    @(negedge clk); set_req(1, 1'b1, 1'b0, 32'd21, 32'd0); #1;
    n_cmp++; if (st !== 8'b0001_0000) begin n_bad++; $display("FAIL rmid_access: got %b want 00010000", st); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({st, bus.mem_addr, bus.mem_wdata} !== 72'd0) begin n_bad++; $display("FAIL rmid_async: got %b/%h/%h want all 0", st, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk); #1;
    n_cmp++; if (st !== 8'h00) begin n_bad++; $display("FAIL rmid_held: got %b want 0", st); end
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'd20, 32'd0);
    #1;
    n_cmp++; if (st[7:6] !== 2'b10) begin n_bad++; $display("FAIL rmid_first_grant: got %b want 10", st[7:6]); end
    @(negedge clk); clr_reqs(); #1;
    n_cmp++; if ({st, bus.mem_addr} !== {8'b0010_0000, 32'd20}) begin n_bad++; $display("FAIL rmid_access2: got %b/%0d", st, bus.mem_addr); end
    @(negedge clk); #1;
    n_cmp++; if ({st, bus.rsp0_rdata} !== {8'b0000_1000, ref_mem[20]}) begin n_bad++; $display("FAIL rmid_dropped_store: got %b/%h want 00001000/%h", st, bus.rsp0_rdata, ref_mem[20]); end
    @(negedge clk);
    $display("reset_mid: rdata %h", bus.rsp0_rdata);
  endtask

  task automatic test_random();
    logic v0, v1, we0, we1, w, we, oor;
    logic [31:0] a0, a1, d0, d1, a, d, e;
    apply_reset();
    for (int it = 0; it < 150; it++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      a0 = rand_addr(); a1 = rand_addr(); d0 = $urandom; d1 = $urandom;
      @(negedge clk);
      set_req(0, v0, we0, a0, d0);
      set_req(1, v1, we1, a1, d1);
      #1;
      if (!v0 && !v1) begin
        n_cmp++; if (st !== 8'h00) begin n_bad++; $display("FAIL rnd_idle it%0d: got %b want 0", it, st); end
        continue;
      end
      w   = (v0 && v1) ? ~last_grant : v1;
      we  = w ? we1 : we0;
      a   = w ? a1 : a0;
      d   = w ? d1 : d0;
      oor = (a >= 32'd256);
      last_grant = w;
      n_cmp++; if (st[7:6] !== {~w, w}) begin n_bad++; $display("FAIL rnd_grant it%0d: got %b want %b", it, st[7:6], {~w, w}); end
      @(negedge clk);
      set_req(0, 1'($urandom_range(0, 1)), 1'b0, rand_addr(), $urandom);
      set_req(1, 1'($urandom_range(0, 1)), 1'b1, rand_addr(), $urandom);
      #1;
      n_cmp++; if ({st, bus.mem_addr} !== {2'b00, !oor && !we, !oor && we, 4'b0000, a}) begin n_bad++; $display("FAIL rnd_access it%0d: got %b/%h want %b/%h", it, st, bus.mem_addr, {2'b00, !oor && !we, !oor && we, 4'b0000}, a); end
      if (we) begin
        n_cmp++; if (bus.mem_wdata !== d) begin n_bad++; $display("FAIL rnd_wdata it%0d: got %h want %h", it, bus.mem_wdata, d); end
      end
      @(negedge clk);
      set_req(0, 1'($urandom_range(0, 1)), 1'b0, rand_addr(), $urandom);
      set_req(1, 1'($urandom_range(0, 1)), 1'b0, rand_addr(), $urandom);
      #1;
      e = (!we && !oor) ? ref_mem[a[7:0]] : 32'd0;
      n_cmp++; if (st !== {4'b0000, ~w, w, ~w && oor, w && oor}) begin n_bad++; $display("FAIL rnd_rsp it%0d: got %b want %b", it, st, {4'b0000, ~w, w, ~w && oor, w && oor}); end
      n_cmp++; if ({bus.rsp0_rdata, bus.rsp1_rdata} !== (w ? {32'd0, e} : {e, 32'd0})) begin n_bad++; $display("FAIL rnd_rdata it%0d: got %h/%h want %h on port %0d", it, bus.rsp0_rdata, bus.rsp1_rdata, e, w); end
      if (we && !oor) ref_mem[a[7:0]] = d;
      $display("random it%0d: port %0d we %0d addr %h err %0d rdata %h", it, w, we, a, oor, e);
    end
    @(negedge clk); clr_reqs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    last_grant = 1'b1;
    test_reset();
    test_simultaneous();
    test_load_p0();
    test_store_load_p1();
    test_out_of_range();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
